// File: rtl/mult4_rr_arbiter.sv
// mult4_rr_arbiter: round-robin sharing of one 4x4 multiplier between N
// requesters, with a tagged, backpressured response register and an
// operation counter.
// Optional feature macro: MULT4_ARB_PIPE_EN adds an operand register in front
// of the multiplier (2-cycle latency); undefined gives a 1-cycle latency.

// Shared 4x4 unsigned combinational multiplier.
module main (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] o
);
    assign o = 8'(x) * 8'(y);
endmodule

module mult4_rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [4*N-1:0]   req_x,
    input  logic [4*N-1:0]   req_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [7:0]       rsp_o,
    output logic [15:0]      ops_cnt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_t;

    stage_t           rsp_st;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   grant;
    logic             any_valid;
    logic [3:0]       gnt_x;
    logic [3:0]       gnt_y;
    logic             rsp_free;
    logic             accept;
    logic             rsp_load;
    logic [3:0]       mul_x;
    logic [3:0]       mul_y;
    logic [IDW-1:0]   load_id;
    logic [7:0]       prod;

    // Round-robin search: first valid at or above ptr, else first valid from 0.
    always_comb begin
        logic           hi_found;
        logic [IDW-1:0] hi_idx;
        logic           lo_found;
        logic [IDW-1:0] lo_idx;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (!hi_found && req_valid[i] && (IDW'(i) >= ptr)) begin
                hi_found = 1'b1;
                hi_idx   = IDW'(i);
            end
            if (!lo_found && req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDW'(i);
            end
        end
        grant     = hi_found ? hi_idx : lo_idx;
        any_valid = lo_found;
    end

    // Operand mux and one-hot ready for the granted requester.
    always_comb begin
        gnt_x     = '0;
        gnt_y     = '0;
        req_ready = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (IDW'(i) == grant) begin
                gnt_x        = req_x[4*i +: 4];
                gnt_y        = req_y[4*i +: 4];
                req_ready[i] = accept;
            end
        end
    end

    assign rsp_valid = (rsp_st == FULL);
    assign rsp_free  = (rsp_st == EMPTY) || rsp_ready;

`ifdef MULT4_ARB_PIPE_EN
    stage_t         op_st;
    logic [3:0]     op_x;
    logic [3:0]     op_y;
    logic [IDW-1:0] op_id;
    logic           op_free;

    // Operand register may take a request when empty or moving on this cycle.
    assign op_free  = (op_st == EMPTY) || rsp_free;
    assign accept   = any_valid && op_free && !rst;
    assign rsp_load = (op_st == FULL) && rsp_free;
    assign mul_x    = op_x;
    assign mul_y    = op_y;
    assign load_id  = op_id;

    // Operand stage: capture accepted operands, empty when advanced without refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_st <= EMPTY;
            op_x  <= '0;
            op_y  <= '0;
            op_id <= '0;
        end else if (accept) begin
            op_st <= FULL;
            op_x  <= gnt_x;
            op_y  <= gnt_y;
            op_id <= grant;
        end else if (rsp_free) begin
            op_st <= EMPTY;
        end
    end
`else
    // Multiplier is fed directly by the granted request.
    assign accept   = any_valid && rsp_free && !rst;
    assign rsp_load = accept;
    assign mul_x    = gnt_x;
    assign mul_y    = gnt_y;
    assign load_id  = grant;
`endif

    main u_mult (
        .x (mul_x),
        .y (mul_y),
        .o (prod)
    );

    // Pointer moves past the winner only on an actual transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant == IDW'(N - 1)) ? '0 : grant + 1'b1;
        end
    end

    // Response register: load on new product, clear on drain, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_st <= EMPTY;
            rsp_id <= '0;
            rsp_o  <= '0;
        end else if (rsp_load) begin
            rsp_st <= FULL;
            rsp_id <= load_id;
            rsp_o  <= prod;
        end else if (rsp_ready) begin
            rsp_st <= EMPTY;
        end
    end

    // Completed-operation counter, wraps modulo 2^16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_cnt <= '0;
        end else if (rsp_valid && rsp_ready) begin
            ops_cnt <= ops_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mult4_rr_arbiter.sv
// Directed self-checking bench for mult4_rr_arbiter (default build, N=4).
// Inputs change and outputs are sampled around the falling clock edge.
module tb_mult4_rr_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_x;
    logic [15:0] req_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_id;
    logic [7:0]  rsp_o;
    logic [15:0] ops_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mult4_rr_arbiter #(.N(4), .IDW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_o     (rsp_o),
        .ops_cnt   (ops_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_op(input int i, input logic [3:0] x, input logic [3:0] y);
        req_x[4*i +: 4] = x;
        req_y[4*i +: 4] = y;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0001;
        set_op(0, 4'd2, 4'd2);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_o !== 8'd4) begin
            n_fail++;
            $display("FAIL pre_reset_rsp: valid=%b o=%0d, required valid=1 o=4", rsp_valid, rsp_o);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 3'd0 || rsp_o !== 8'd0 || ops_cnt !== 16'd0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b id=%0d o=%0d cnt=%0d ready=%b, required all zero",
                     rsp_valid, rsp_id, rsp_o, ops_cnt, req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b0100;
        set_op(2, 4'd3, 4'd5);
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL post_reset_ready: got %b, required 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_o !== 8'd15 || rsp_id !== 3'd2) begin
            n_fail++;
            $display("FAIL post_reset_rsp: valid=%b o=%0d id=%0d, required 1/15/2", rsp_valid, rsp_o, rsp_id);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_p [5];
        int         exp_g [5];
        exp_p = '{8'd2, 8'd6, 8'd12, 8'd20, 8'd2};
        exp_g = '{0, 1, 2, 3, 0};
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_op(i, 4'(i + 1), 4'(i + 2));
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) req_valid = '0;
            #1;
            if (k < 5) begin
                n_checks++;
                if (req_ready !== (4'b0001 << exp_g[k])) begin
                    n_fail++;
                    $display("FAIL rr_grant[%0d]: ready=%b, required grant %0d", k, req_ready, exp_g[k]);
                end
            end
            if (k >= 1) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_o !== exp_p[k-1] || rsp_id !== 3'(exp_g[k-1])
                    || ops_cnt !== 16'(k - 1)) begin
                    n_fail++;
                    $display("FAIL rr_rsp[%0d]: valid=%b o=%0d id=%0d cnt=%0d, required 1/%0d/%0d/%0d",
                             k - 1, rsp_valid, rsp_o, rsp_id, ops_cnt, exp_p[k-1], exp_g[k-1], k - 1);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (ops_cnt !== 16'd5 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_final: cnt=%0d valid=%b, required 5/0", ops_cnt, rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b0;
        set_op(1, 4'd15, 4'd15);
        req_valid = 4'b0010;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_first_ready: got %b, required 0010", req_ready);
        end
        @(negedge clk);
        set_op(0, 4'd1, 4'd1);
        set_op(3, 4'd1, 4'd1);
        req_valid = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_o !== 8'd225 || rsp_id !== 3'd1
                || req_ready !== 4'b0000 || ops_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b o=%0d id=%0d ready=%b cnt=%0d, required 1/225/1/0000/0",
                         k, rsp_valid, rsp_o, rsp_id, req_ready, ops_cnt);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b, required 1000", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0001;
        n_checks++;
        if (ops_cnt !== 16'd1 || rsp_o !== 8'd1 || rsp_id !== 3'd3) begin
            n_fail++;
            $display("FAIL bp_drain: cnt=%0d o=%0d id=%0d, required 1/1/3", ops_cnt, rsp_o, rsp_id);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b0;
        set_op(0, 4'd2, 4'd4);
        req_valid = 4'b0001;
        @(negedge clk);
        set_op(3, 4'd7, 4'd9);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_o !== 8'd8 || req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL b2b_accept: valid=%b o=%0d ready=%b, required 1/8/1000", rsp_valid, rsp_o, req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_o !== 8'd63 || rsp_id !== 3'd3 || ops_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL b2b_rsp: valid=%b o=%0d id=%0d cnt=%0d, required 1/63/3/1",
                     rsp_valid, rsp_o, rsp_id, ops_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || ops_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL b2b_empty: valid=%b cnt=%0d, required 0/2", rsp_valid, ops_cnt);
        end
    endtask

    task automatic test_ptr_wrap();
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b1;
        set_op(2, 4'd1, 4'd1);
        req_valid = 4'b0100;
        @(negedge clk);
        set_op(3, 4'd2, 4'd3);
        set_op(0, 4'd4, 4'd5);
        req_valid = 4'b1001;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_grant3: ready=%b, required 1000", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001 || rsp_o !== 8'd6 || rsp_id !== 3'd3) begin
            n_fail++;
            $display("FAIL wrap_grant0: ready=%b o=%0d id=%0d, required 0001/6/3", req_ready, rsp_o, rsp_id);
        end
        @(negedge clk);
        set_op(3, 4'd6, 4'd6);
        req_valid = 4'b1001;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000 || rsp_o !== 8'd20 || rsp_id !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_ptr1: ready=%b o=%0d id=%0d, required 1000/20/0", req_ready, rsp_o, rsp_id);
        end
        @(negedge clk);
        req_valid = '0;
        n_checks++;
        if (rsp_o !== 8'd36 || rsp_id !== 3'd3) begin
            n_fail++;
            $display("FAIL wrap_last: o=%0d id=%0d, required 36/3", rsp_o, rsp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive();
        logic [7:0] prev;
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b1;
        prev      = '0;
        for (int k = 0; k <= 256; k++) begin
            if (k < 256) begin
                set_op(0, 4'(k >> 4), 4'(k & 15));
                req_valid = 4'b0001;
            end else begin
                req_valid = '0;
            end
            #1;
            if (k < 256) begin
                n_checks++;
                if (req_ready !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL exh_ready[%0d]: got %b, required 0001", k, req_ready);
                end
            end
            if (k >= 1) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_o !== 8'((prev >> 4) * (prev & 8'd15)) || rsp_id !== 3'd0) begin
                    n_fail++;
                    $display("FAIL exh_prod[%0d*%0d]: valid=%b o=%0d id=%0d, required 1/%0d/0",
                             prev >> 4, prev & 8'd15, rsp_valid, rsp_o, rsp_id, (prev >> 4) * (prev & 8'd15));
                end
            end
            prev = 8'(k);
            @(negedge clk);
        end
        n_checks++;
        if (ops_cnt !== 16'd256 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL exh_count: cnt=%0d valid=%b, required 256/0", ops_cnt, rsp_valid);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 3'd0 || rsp_o !== 8'd0 || ops_cnt !== 16'd0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b id=%0d o=%0d cnt=%0d ready=%b, required all zero",
                     rsp_valid, rsp_id, rsp_o, ops_cnt, req_ready);
        end
        test_reset();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        test_ptr_wrap();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
